// File: rtl/wb_mtimer_pkg.sv
// Shared definitions for the Wishbone machine timer: register word offsets,
// the control register layout and the byte-lane merge helper.
package wb_mtimer_pkg;

  localparam logic [2:0] MTIME_LO_OFS    = 3'd0;
  localparam logic [2:0] MTIME_HI_OFS    = 3'd1;
  localparam logic [2:0] MTIMECMP_LO_OFS = 3'd2;
  localparam logic [2:0] MTIMECMP_HI_OFS = 3'd3;
  localparam logic [2:0] CTRL_OFS        = 3'd4;

  localparam int DIV_W_MAX = 16;

  // Packs to the CTRL read layout: DIV in [31:16], EN in bit 0.
  typedef struct packed {
    logic [DIV_W_MAX-1:0] div;
    logic [14:0]          rsvd;
    logic                 en;
  } ctrl_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Pipelined Wishbone B4 bus bundle with master and slave views.
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (output cyc, stb, we, adr, sel, dat_m,
                  input  dat_s, ack, err, stall);
  modport slave  (input  cyc, stb, we, adr, sel, dat_m,
                  output dat_s, ack, err, stall);
endinterface

// File: rtl/wb_mtimer_prescaler.sv
// Divider counter producing one tick every DIV+1 enabled clocks.
module wb_mtimer_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             div_wr,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  assign tick = en && (count == div);

  // A DIV rewrite restarts the spacing so the new period starts cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!en || div_wr || tick) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/wb_mtimer.sv
// RISC-V machine timer (mtime/mtimecmp) as a pipelined Wishbone slave,
// driving a registered level interrupt for the core.
module wb_mtimer
  import wb_mtimer_pkg::*;
#(
  parameter int               DIV_W     = 16,
  parameter logic [DIV_W-1:0] DIV_RESET = '0
) (
  input  logic clk,
  input  logic rst,
  wb_if.slave  wb,
  output logic irq_timer
);

  localparam logic [3:0] DIV_SEL_MASK = (DIV_W > 8) ? 4'b1100 : 4'b0100;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  ctrl_t       ctrl;
  logic        tick;

  logic        accept;
  logic        mapped;
  logic        wr;
  logic        div_wr;
  logic [2:0]  ofs;
  logic [31:0] rd_data;
  logic [31:0] ctrl_merged;
  logic [63:0] mtime_inc;
  logic [63:0] mtime_next;
  logic        unused_adr;

  assign wb.stall    = 1'b0;
  assign accept      = wb.cyc & wb.stb;
  assign ofs         = wb.adr[4:2];
  assign mapped      = (ofs <= CTRL_OFS);
  assign wr          = accept & wb.we & mapped;
  assign ctrl_merged = byte_merge(ctrl, wb.dat_m, wb.sel);
  assign div_wr      = wr && (ofs == CTRL_OFS) && |(wb.sel & DIV_SEL_MASK);
  assign unused_adr  = ^{wb.adr[31:5], wb.adr[1:0]};

  wb_mtimer_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (ctrl.en),
    .div    (ctrl.div[DIV_W-1:0]),
    .div_wr (div_wr),
    .tick   (tick)
  );

  always_comb begin
    rd_data = '0;
    unique case (ofs)
      MTIME_LO_OFS:    rd_data = mtime[31:0];
      MTIME_HI_OFS:    rd_data = mtime[63:32];
      MTIMECMP_LO_OFS: rd_data = mtimecmp[31:0];
      MTIMECMP_HI_OFS: rd_data = mtimecmp[63:32];
      CTRL_OFS:        rd_data = ctrl;
      default:         rd_data = '0;
    endcase
  end

  // Written bytes override the tick; untouched bytes keep the incremented
  // value, whose carry comes from the pre-write count.
  always_comb begin
    mtime_inc  = mtime + 64'(tick);
    mtime_next = mtime_inc;
    if (wr && ofs == MTIME_LO_OFS) begin
      mtime_next[31:0] = byte_merge(mtime_inc[31:0], wb.dat_m, wb.sel);
    end
    if (wr && ofs == MTIME_HI_OFS) begin
      mtime_next[63:32] = byte_merge(mtime_inc[63:32], wb.dat_m, wb.sel);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      ctrl      <= '{div: DIV_W_MAX'(DIV_RESET), rsvd: '0, en: 1'b0};
      irq_timer <= 1'b0;
      wb.ack    <= 1'b0;
      wb.err    <= 1'b0;
      wb.dat_s  <= '0;
    end else begin
      mtime     <= mtime_next;
      irq_timer <= (mtime >= mtimecmp);
      if (wr && ofs == MTIMECMP_LO_OFS) begin
        mtimecmp[31:0] <= byte_merge(mtimecmp[31:0], wb.dat_m, wb.sel);
      end
      if (wr && ofs == MTIMECMP_HI_OFS) begin
        mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], wb.dat_m, wb.sel);
      end
      if (wr && ofs == CTRL_OFS) begin
        ctrl.en  <= ctrl_merged[0];
        ctrl.div <= DIV_W_MAX'(ctrl_merged[16 +: DIV_W]);
      end
      wb.ack   <= accept & mapped;
      wb.err   <= accept & ~mapped;
      wb.dat_s <= (accept & mapped) ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_wb_mtimer.sv
// Self-checking bench for wb_mtimer: directed bus traffic, a per-cycle
// reference model of the timer, and hand-computed spot checks.
module tb_wb_mtimer;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] A_MLO  = BASE + 32'h00;
  localparam logic [31:0] A_MHI  = BASE + 32'h04;
  localparam logic [31:0] A_CLO  = BASE + 32'h08;
  localparam logic [31:0] A_CHI  = BASE + 32'h0C;
  localparam logic [31:0] A_CTRL = BASE + 32'h10;

  logic clk;
  logic rst;
  logic irq_timer;
  int   tests_run;
  int   tests_failed;

  wb_if bus ();

  wb_mtimer dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (bus),
    .irq_timer (irq_timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: mtime counts ticks that fall every (DIV+1) enabled
  // cycles since the last enable or DIV write.
  logic [63:0] m_mtime, m_cmp, m_next;
  logic        m_en, m_en_next;
  int unsigned m_div, m_div_next, m_phase;
  logic [31:0] m_rd, m_word;
  logic        m_tick, m_acc, m_map, m_divwr;
  int          m_idx;
  logic        exp_ack, exp_err, exp_irq;
  logic [31:0] exp_dat;

  function automatic logic [31:0] applySel(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mtime = '0; m_cmp = '1; m_en = 1'b0; m_div = 0; m_phase = 0;
      exp_ack = 1'b0; exp_err = 1'b0; exp_dat = '0; exp_irq = 1'b0;
    end else begin
      m_acc = bus.cyc && bus.stb;
      m_idx = int'(bus.adr[4:2]);
      m_map = (m_idx < 5);
      case (m_idx)
        0:       m_rd = m_mtime[31:0];
        1:       m_rd = m_mtime[63:32];
        2:       m_rd = m_cmp[31:0];
        3:       m_rd = m_cmp[63:32];
        4:       m_rd = (m_div << 16) | {31'd0, m_en};
        default: m_rd = '0;
      endcase
      exp_irq = (m_mtime >= m_cmp);
      exp_ack = m_acc && m_map;
      exp_err = m_acc && !m_map;
      exp_dat = exp_ack ? m_rd : 32'd0;
      m_tick  = m_en && ((m_phase % (m_div + 1)) == m_div);
      m_next  = m_mtime + (m_tick ? 64'd1 : 64'd0);
      m_divwr = 1'b0;
      m_en_next  = m_en;
      m_div_next = m_div;
      if (m_acc && m_map && bus.we) begin
        case (m_idx)
          0: m_next[31:0]  = applySel(m_next[31:0], bus.dat_m, bus.sel);
          1: m_next[63:32] = applySel(m_next[63:32], bus.dat_m, bus.sel);
          2: m_cmp[31:0]   = applySel(m_cmp[31:0], bus.dat_m, bus.sel);
          3: m_cmp[63:32]  = applySel(m_cmp[63:32], bus.dat_m, bus.sel);
          default: begin
            m_word     = applySel(m_rd, bus.dat_m, bus.sel);
            m_divwr    = |bus.sel[3:2];
            m_en_next  = m_word[0];
            m_div_next = int'(m_word[31:16]);
          end
        endcase
      end
      m_phase = (!m_en || m_divwr) ? 0 : m_phase + 1;
      m_mtime = m_next;
      m_en    = m_en_next;
      m_div   = m_div_next;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("cyc_ack",   bus.ack,   exp_ack);
      checkOutput("cyc_err",   bus.err,   exp_err);
      checkOutput("cyc_dat_s", bus.dat_s, exp_dat);
      checkOutput("cyc_stall", bus.stall, 1'b0);
      checkOutput("cyc_irq",   irq_timer, exp_irq);
    end
  end

  // One request: driven after a falling edge, accepted at the next rising
  // edge, response sampled on the falling edge after that.
  task automatic applyStimulus(input logic we_i, input logic [31:0] adr_i,
                               input logic [3:0] sel_i, input logic [31:0] dat_i,
                               output logic [31:0] rdata, output logic got_ack,
                               output logic got_err);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we_i;
    bus.adr = adr_i; bus.sel = sel_i; bus.dat_m = dat_i;
    @(posedge clk);
    @(negedge clk);
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    rdata = bus.dat_s; got_ack = bus.ack; got_err = bus.err;
  endtask

  task automatic busWrite(input logic [31:0] adr_i, input logic [31:0] dat_i,
                          input logic [3:0] sel_i = 4'hF);
    logic [31:0] d;
    logic a, e;
    applyStimulus(1'b1, adr_i, sel_i, dat_i, d, a, e);
    checkOutput("write_ack", a, 1'b1);
  endtask

  task automatic busRead(input string name, input logic [31:0] adr_i,
                         input logic [31:0] expected);
    logic [31:0] d;
    logic a, e;
    applyStimulus(1'b0, adr_i, 4'hF, 32'd0, d, a, e);
    checkOutput({name, "_ack"}, a, 1'b1);
    checkOutput(name, d, expected);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] d;
    logic a, e;
    logic [31:0] p_adr [4];
    logic [31:0] p_exp [4];
    tests_run = 0; tests_failed = 0;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.adr = '0; bus.sel = '0; bus.dat_m = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    busRead("rst_mtime_lo", A_MLO, 32'h0);
    busRead("rst_mtime_hi", A_MHI, 32'h0);
    busRead("rst_cmp_lo", A_CLO, 32'hFFFF_FFFF);
    busRead("rst_cmp_hi", A_CHI, 32'hFFFF_FFFF);
    busRead("rst_ctrl", A_CTRL, 32'h0);
    checkOutput("rst_irq", irq_timer, 1'b0);

    busWrite(A_CTRL, 32'h1);
    repeat (10) @(negedge clk);
    busRead("count_div0", A_MLO, 32'd10);

    busWrite(A_CTRL, 32'h0);
    busWrite(A_MLO, 32'h0);
    busWrite(A_MHI, 32'h0);
    busWrite(A_CTRL, 32'h0003_0001);
    repeat (40) @(negedge clk);
    busRead("presc_40cyc", A_MLO, 32'd10);
    busWrite(A_CTRL, 32'h0003_0001);
    repeat (3) @(negedge clk);
    busRead("presc_restart", A_MLO, 32'd10);
    busRead("presc_after", A_MLO, 32'd11);
    busRead("ctrl_readback", A_CTRL, 32'h0003_0001);

    busWrite(A_CTRL, 32'h0);
    busWrite(A_MLO, 32'h0);
    busWrite(A_MHI, 32'h0);
    busWrite(A_CHI, 32'h0);
    busWrite(A_CLO, 32'd20);
    busWrite(A_CTRL, 32'h1);
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      if (i == 20) checkOutput("irq_before", irq_timer, 1'b0);
      if (i == 21) checkOutput("irq_rise", irq_timer, 1'b1);
    end
    busWrite(A_CLO, 32'd1000);
    checkOutput("irq_hold", irq_timer, 1'b1);
    @(negedge clk);
    checkOutput("irq_fall", irq_timer, 1'b0);

    busWrite(A_CTRL, 32'h0);
    busWrite(A_MHI, 32'h0);
    busWrite(A_MLO, 32'hFFFF_FFFE);
    busWrite(A_CTRL, 32'h1);
    repeat (2) @(negedge clk);
    busRead("carry_hi", A_MHI, 32'd1);

    busWrite(A_CTRL, 32'h0);
    busWrite(A_MHI, 32'h0);
    busWrite(A_MLO, 32'h1234_56FF);
    busWrite(A_CTRL, 32'h1);
    busWrite(A_MLO, 32'h0000_0011, 4'b0001);
    busWrite(A_CTRL, 32'h0);
    busRead("collision_lo", A_MLO, 32'h1234_5712);
    busRead("collision_hi", A_MHI, 32'h0);

    busWrite(A_CLO, 32'd5, 4'b0000);
    busRead("sel0_noop", A_CLO, 32'd1000);

    applyStimulus(1'b0, BASE + 32'h18, 4'hF, 32'd0, d, a, e);
    checkOutput("unmapped_err", e, 1'b1);
    checkOutput("unmapped_ack", a, 1'b0);
    checkOutput("unmapped_dat", d, 32'd0);
    applyStimulus(1'b1, BASE + 32'h14, 4'hF, 32'hDEAD_BEEF, d, a, e);
    checkOutput("unmapped_wr_err", e, 1'b1);

    p_adr[0] = A_MLO; p_exp[0] = 32'h1234_5712;
    p_adr[1] = A_MHI; p_exp[1] = 32'h0;
    p_adr[2] = A_CLO; p_exp[2] = 32'd1000;
    p_adr[3] = A_CHI; p_exp[3] = 32'h0;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.sel = 4'hF;
    bus.adr = p_adr[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i < 3) begin
        bus.adr = p_adr[i+1];
      end else begin
        bus.cyc = 1'b0; bus.stb = 1'b0;
      end
      checkOutput("pipe_ack", bus.ack, 1'b1);
      checkOutput("pipe_dat", bus.dat_s, p_exp[i]);
    end
    @(negedge clk);
    checkOutput("pipe_idle_ack", bus.ack, 1'b0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
